// File: rtl/game_pkg.sv
// Shared state encodings and width/time helpers for the parametrised grid game controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SELECT_DIFF = 3'd1,
    LOADING     = 3'd2,
    NAVIGATE    = 3'd3,
    PICK        = 3'd4,
    VICTORY     = 3'd5,
    DEFEAT      = 3'd6,
    PAUSED      = 3'd7
  } game_state_t;

  // A cell holds 0..N, where N is the side of the grid (BOX*BOX).
  function automatic int cell_width(input int box);
    return $clog2(box * box + 1);
  endfunction

  function automatic int coord_width(input int box);
    int n;
    n = box * box;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int index_width(input int box);
    int cells;
    cells = box * box * box * box;
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

  function automatic int diff_width(input int num_diff);
    return (num_diff > 1) ? $clog2(num_diff) : 1;
  endfunction

  function automatic int time_limit(input int diff, input int base, input int step);
    return base - diff * step;
  endfunction

endpackage

// File: rtl/game_fsm_grid_cursor_ctrl.sv
// Wrap-around cursor for the game grid; one move per enabled cycle, priority up > down > left > right.
module cursor_ctrl
  import game_pkg::*;
#(
  parameter int BOX = 3,
  localparam int N  = BOX * BOX,
  localparam int PW = coord_width(BOX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  output logic [PW-1:0] pos_i,
  output logic [PW-1:0] pos_j
);

  localparam logic [PW-1:0] LAST = PW'(N - 1);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      pos_i <= '0;
      pos_j <= '0;
    end else if (en) begin
      if (up)
        pos_i <= (pos_i == '0) ? LAST : pos_i - PW'(1);
      else if (down)
        pos_i <= (pos_i == LAST) ? '0 : pos_i + PW'(1);
      else if (left)
        pos_j <= (pos_j == '0) ? LAST : pos_j - PW'(1);
      else if (right)
        pos_j <= (pos_j == LAST) ? '0 : pos_j + PW'(1);
    end
  end

endmodule

// File: rtl/game_fsm_grid.sv
// Grid game controller: FSM, picker, strikes, countdown and board state for any BOX x BOX grid.
// Optional pause during play is enabled by defining GAME_PAUSE_EN.
module game_fsm_grid
  import game_pkg::*;
#(
  parameter int BOX         = 3,
  parameter int NUM_DIFF    = 2,
  parameter int MAX_STRIKES = 3,
  parameter int TIME_BASE   = 600,
  parameter int TIME_STEP   = 120,
  localparam int N  = BOX * BOX,
  localparam int CW = cell_width(BOX),
  localparam int PW = coord_width(BOX),
  localparam int DW = diff_width(NUM_DIFF),
  localparam int SW = $clog2(MAX_STRIKES + 1),
  localparam int TW = $clog2(TIME_BASE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              up_button,
  input  logic              down_button,
  input  logic              left_button,
  input  logic              right_button,
  input  logic              start_button,
  input  logic              a_button,
  input  logic              b_button,
  input  logic              load_valid,
  input  logic [N*N*CW-1:0] load_map,
  input  logic [N*N-1:0]    load_vis,
  output logic              load_ready,
  output logic [2:0]        state,
  output logic [PW-1:0]     pos_i,
  output logic [PW-1:0]     pos_j,
  output logic [CW-1:0]     selected_number,
  output logic [SW-1:0]     strikes,
  output logic [TW-1:0]     seconds_left,
  output logic [DW-1:0]     difficulty,
  output logic [N*N*CW-1:0] board,
  output logic [N*N-1:0]    visibilities,
  output logic              error,
  output logic              playing
);

  localparam int CELLS = N * N;
  localparam int IW    = index_width(BOX);

  localparam logic [DW-1:0] DIFF_MAX   = DW'(NUM_DIFF - 1);
  localparam logic [SW-1:0] STRIKE_MAX = SW'(MAX_STRIKES);
  localparam logic [CW-1:0] NUM_MAX    = CW'(N);
  localparam logic [CW-1:0] NUM_MIN    = CW'(1);

  game_state_t state_reg;
`ifdef GAME_PAUSE_EN
  game_state_t resume_reg;
`endif

  logic [IW-1:0] cell_idx;
  logic [CW-1:0] cell_sol [CELLS];
  logic [TW-1:0] time_for_diff;
  logic          cell_visible;
  logic          all_visible;
  logic          lose;
  logic          end_hit;
  logic          cursor_en;
  logic          cursor_clear;

  generate
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
      assign cell_sol[gi] = board[gi*CW +: CW];
    end
  endgenerate

  assign cell_idx      = IW'(pos_i) * IW'(N) + IW'(pos_j);
  assign cell_visible  = visibilities[cell_idx];
  assign all_visible   = &visibilities;
  assign lose          = (strikes == STRIKE_MAX) || (seconds_left == '0);
  assign end_hit       = lose || all_visible;
  assign time_for_diff = TW'(time_limit(int'(difficulty), TIME_BASE, TIME_STEP));

  assign state      = state_reg;
  assign load_ready = (state_reg == LOADING);
  assign playing    = (state_reg == NAVIGATE) || (state_reg == PICK);

  // The end-of-game check pre-empts any cursor movement on the same edge.
  assign cursor_en    = (state_reg == NAVIGATE) && !end_hit;
  assign cursor_clear = load_ready && load_valid;

  cursor_ctrl #(
    .BOX (BOX)
  ) u_cursor (
    .clk   (clk),
    .reset (reset),
    .clear (cursor_clear),
    .en    (cursor_en),
    .up    (up_button),
    .down  (down_button),
    .left  (left_button),
    .right (right_button),
    .pos_i (pos_i),
    .pos_j (pos_j)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      selected_number <= NUM_MIN;
      strikes         <= '0;
      seconds_left    <= '0;
      difficulty      <= '0;
      board           <= '0;
      visibilities    <= '0;
      error           <= 1'b0;
`ifdef GAME_PAUSE_EN
      resume_reg      <= IDLE;
`endif
    end else begin
      error <= 1'b0;

      if (playing && tick && (seconds_left != '0))
        seconds_left <= seconds_left - TW'(1);

      case (state_reg)
        IDLE: begin
          if (start_button)
            state_reg <= SELECT_DIFF;
        end

        SELECT_DIFF: begin
          if (up_button) begin
            if (difficulty != DIFF_MAX)
              difficulty <= difficulty + DW'(1);
          end else if (down_button) begin
            if (difficulty != '0)
              difficulty <= difficulty - DW'(1);
          end
          if (a_button)
            state_reg <= LOADING;
        end

        LOADING: begin
          if (load_valid) begin
            board           <= load_map;
            visibilities    <= load_vis;
            seconds_left    <= time_for_diff;
            strikes         <= '0;
            selected_number <= NUM_MIN;
            state_reg       <= NAVIGATE;
          end
        end

        NAVIGATE: begin
          if (lose)
            state_reg <= DEFEAT;
          else if (all_visible)
            state_reg <= VICTORY;
`ifdef GAME_PAUSE_EN
          else if (start_button) begin
            state_reg  <= PAUSED;
            resume_reg <= NAVIGATE;
          end
`endif
          else if (a_button && !cell_visible) begin
            state_reg       <= PICK;
            selected_number <= NUM_MIN;
          end
        end

        PICK: begin
          if (lose)
            state_reg <= DEFEAT;
          else if (all_visible)
            state_reg <= VICTORY;
`ifdef GAME_PAUSE_EN
          else if (start_button) begin
            state_reg  <= PAUSED;
            resume_reg <= PICK;
          end
`endif
          else if (a_button) begin
            if (selected_number == cell_sol[cell_idx]) begin
              visibilities <= visibilities | (CELLS'(1) << cell_idx);
              state_reg    <= NAVIGATE;
            end else begin
              error <= 1'b1;
              if (strikes != STRIKE_MAX)
                strikes <= strikes + SW'(1);
            end
          end else if (b_button)
            state_reg <= NAVIGATE;
          else if (up_button)
            selected_number <= (selected_number == NUM_MAX) ? NUM_MIN : selected_number + CW'(1);
          else if (down_button)
            selected_number <= (selected_number == NUM_MIN) ? NUM_MAX : selected_number - CW'(1);
        end

`ifdef GAME_PAUSE_EN
        PAUSED: begin
          if (start_button)
            state_reg <= resume_reg;
        end
`endif

        VICTORY, DEFEAT: begin
          if (start_button)
            state_reg <= SELECT_DIFF;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_fsm_grid.sv
// Scenario bench for game_fsm_grid (BOX=3 defaults); expectations queued per step and compared after each edge.
`timescale 1ns/1ps
module tb_game_fsm_grid;

  localparam int N = 9, CELLS = 81, CW = 4, PW = 4, SW = 2, TW = 10, DW = 1;
  localparam logic [6:0] B_UP = 7'd1, B_DN = 7'd2, B_LT = 7'd4, B_RT = 7'd8;
  localparam logic [6:0] B_ST = 7'd16, B_A = 7'd32, B_B = 7'd64;
  localparam int K_STATE = 0, K_PI = 1, K_PJ = 2, K_SEL = 3, K_STR = 4, K_SEC = 5;
  localparam int K_DIFF = 6, K_BOARD = 7, K_VIS = 8, K_ERR = 9, K_PLAY = 10, K_RDY = 11;

  typedef struct {
    int           kind;
    logic [511:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic [6:0] btn = '0;
  logic load_valid = 1'b0;
  logic [CELLS*CW-1:0] load_map;
  logic [CELLS-1:0] load_vis;
  logic load_ready, error, playing;
  logic [2:0] state;
  logic [PW-1:0] pos_i, pos_j;
  logic [CW-1:0] selected_number;
  logic [SW-1:0] strikes;
  logic [TW-1:0] seconds_left;
  logic [DW-1:0] difficulty;
  logic [CELLS*CW-1:0] board;
  logic [CELLS-1:0] visibilities;

  logic [CELLS*CW-1:0] map_ref;
  logic [CELLS-1:0] one_hidden, all_vis;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_fsm_grid dut (
    .clk             (clk),
    .reset           (reset),
    .tick            (tick),
    .up_button       (btn[0]),
    .down_button     (btn[1]),
    .left_button     (btn[2]),
    .right_button    (btn[3]),
    .start_button    (btn[4]),
    .a_button        (btn[5]),
    .b_button        (btn[6]),
    .load_valid      (load_valid),
    .load_map        (load_map),
    .load_vis        (load_vis),
    .load_ready      (load_ready),
    .state           (state),
    .pos_i           (pos_i),
    .pos_j           (pos_j),
    .selected_number (selected_number),
    .strikes         (strikes),
    .seconds_left    (seconds_left),
    .difficulty      (difficulty),
    .board           (board),
    .visibilities    (visibilities),
    .error           (error),
    .playing         (playing)
  );

  function automatic void want(input int k, input logic [511:0] v);
    exp_t x;
    x.kind = k;
    x.val  = v;
    sb.push_back(x);
  endfunction

  function automatic logic [511:0] observe(input int k);
    case (k)
      K_STATE: return 512'(state);
      K_PI:    return 512'(pos_i);
      K_PJ:    return 512'(pos_j);
      K_SEL:   return 512'(selected_number);
      K_STR:   return 512'(strikes);
      K_SEC:   return 512'(seconds_left);
      K_DIFF:  return 512'(difficulty);
      K_BOARD: return 512'(board);
      K_VIS:   return 512'(visibilities);
      K_ERR:   return 512'(error);
      K_PLAY:  return 512'(playing);
      K_RDY:   return 512'(load_ready);
      default: return '0;
    endcase
  endfunction

  function automatic string kind_name(input int k);
    case (k)
      K_STATE: return "state";
      K_PI:    return "pos_i";
      K_PJ:    return "pos_j";
      K_SEL:   return "selected_number";
      K_STR:   return "strikes";
      K_SEC:   return "seconds_left";
      K_DIFF:  return "difficulty";
      K_BOARD: return "board";
      K_VIS:   return "visibilities";
      K_ERR:   return "error";
      K_PLAY:  return "playing";
      K_RDY:   return "load_ready";
      default: return "unknown";
    endcase
  endfunction

  task automatic step(input logic [6:0] b, input logic t, input logic lv);
    btn = b;
    tick = t;
    load_valid = lv;
    @(posedge clk);
    #1;
    btn = '0;
    tick = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [511:0] o;
    reset = 1'b0;
    btn = B_ST | B_A;
    load_valid = 1'b1;
    tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    btn = '0;
    load_valid = 1'b0;
    tick = 1'b0;
    want(K_STATE, 0); want(K_SEL, 1); want(K_PI, 0); want(K_PJ, 0);
    want(K_STR, 0); want(K_SEC, 0); want(K_DIFF, 0); want(K_BOARD, 0);
    want(K_VIS, 0); want(K_ERR, 0); want(K_PLAY, 0); want(K_RDY, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.kind);
      n_cmp++;
      if (o !== e.val) begin
        n_bad++;
        $display("FAIL reset %s: got %0h want %0h", kind_name(e.kind), o, e.val);
      end
    end
    $display("reset: checked");
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    exp_t e;
    logic [511:0] o;
    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0: begin step(B_ST, 0, 0); want(K_STATE, 1); end
        1: begin step(B_A, 0, 0); want(K_STATE, 2); want(K_RDY, 1); end
        default: begin
          reset = 1'b0;
          step('0, 0, 1);
          reset = 1'b1;
          want(K_STATE, 0); want(K_BOARD, 0); want(K_VIS, 0); want(K_SEC, 0); want(K_RDY, 0);
        end
      endcase
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = observe(e.kind);
        n_cmp++;
        if (o !== e.val) begin
          n_bad++;
          $display("FAIL reset_mid_load ph%0d %s: got %0h want %0h", ph, kind_name(e.kind), o, e.val);
        end
      end
      $display("reset_mid_load ph%0d: state=%0d", ph, state);
    end
  endtask

  task automatic test_load();
    exp_t e;
    logic [511:0] o;
    load_vis = one_hidden;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin step(B_ST, 0, 0); want(K_STATE, 1); want(K_RDY, 0); end
        1: begin step(B_A, 0, 0); want(K_STATE, 2); want(K_RDY, 1); end
        2: begin repeat (3) step('0, 0, 0); want(K_STATE, 2); want(K_RDY, 1); end
        default: begin
          step('0, 0, 1);
          want(K_STATE, 3); want(K_SEC, 600); want(K_RDY, 0); want(K_BOARD, map_ref);
          want(K_VIS, one_hidden); want(K_STR, 0); want(K_PI, 0); want(K_PJ, 0);
          want(K_SEL, 1); want(K_PLAY, 1);
        end
      endcase
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = observe(e.kind);
        n_cmp++;
        if (o !== e.val) begin
          n_bad++;
          $display("FAIL load ph%0d %s: got %0h want %0h", ph, kind_name(e.kind), o, e.val);
        end
      end
      $display("load ph%0d: state=%0d seconds=%0d", ph, state, seconds_left);
    end
  endtask

  task automatic test_cursor();
    exp_t e;
    logic [511:0] o;
    logic [6:0] seq_b [11];
    int seq_i [11];
    int seq_j [11];
    seq_b = '{B_UP, B_LT, B_UP | B_RT, B_DN, B_DN, B_RT, B_LT | B_RT, B_RT, B_RT, B_A, B_LT};
    seq_i = '{8, 8, 7, 8, 0, 0, 0, 0, 0, 0, 0};
    seq_j = '{0, 8, 8, 8, 8, 0, 8, 0, 1, 1, 0};
    for (int ph = 0; ph < 11; ph++) begin
      step(seq_b[ph], 0, 0);
      want(K_PI, seq_i[ph]);
      want(K_PJ, seq_j[ph]);
      want(K_STATE, 3);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = observe(e.kind);
        n_cmp++;
        if (o !== e.val) begin
          n_bad++;
          $display("FAIL cursor ph%0d %s: got %0h want %0h", ph, kind_name(e.kind), o, e.val);
        end
      end
      $display("cursor ph%0d: pos=(%0d,%0d)", ph, pos_i, pos_j);
    end
  endtask

  task automatic test_pick();
    exp_t e;
    logic [511:0] o;
    for (int ph = 0; ph < 14; ph++) begin
      case (ph)
        0: begin step(B_A, 0, 0); want(K_STATE, 4); want(K_SEL, 1); end
        1: begin step(B_B, 0, 0); want(K_STATE, 3); want(K_VIS, one_hidden); end
        2: begin step(B_A, 0, 0); want(K_STATE, 4); end
        3: begin step(B_DN, 0, 0); want(K_SEL, 9); end
        4: begin step(B_A, 0, 0); want(K_ERR, 1); want(K_STR, 1); want(K_STATE, 4); end
        5: begin step('0, 0, 0); want(K_ERR, 0); want(K_STR, 1); end
        6, 7, 8, 9, 10: begin step(B_UP, 0, 0); want(K_SEL, ph - 5); end
        11: begin step(B_A, 0, 0); want(K_STATE, 3); want(K_VIS, all_vis); want(K_ERR, 0); end
        12: begin step('0, 0, 0); want(K_STATE, 5); want(K_PLAY, 0); end
        default: begin step(B_ST, 0, 0); want(K_STATE, 1); want(K_DIFF, 0); end
      endcase
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = observe(e.kind);
        n_cmp++;
        if (o !== e.val) begin
          n_bad++;
          $display("FAIL pick ph%0d %s: got %0h want %0h", ph, kind_name(e.kind), o, e.val);
        end
      end
      $display("pick ph%0d: state=%0d sel=%0d strikes=%0d", ph, state, selected_number, strikes);
    end
  endtask

  task automatic test_strikes();
    exp_t e;
    logic [511:0] o;
    load_vis = one_hidden;
    for (int ph = 0; ph < 11; ph++) begin
      case (ph)
        0: begin step(B_DN, 0, 0); want(K_DIFF, 0); end
        1: begin step(B_UP, 0, 0); want(K_DIFF, 1); end
        2: begin step(B_UP, 0, 0); want(K_DIFF, 1); end
        3: begin step(B_A, 0, 0); want(K_STATE, 2); end
        4: begin step('0, 0, 1); want(K_STATE, 3); want(K_SEC, 600 - 120); want(K_STR, 0); end
        5: begin step(B_A, 0, 0); want(K_STATE, 4); end
        6: begin step(B_A, 0, 0); want(K_ERR, 1); want(K_STR, 1); end
        7: begin step(B_A, 0, 0); want(K_ERR, 1); want(K_STR, 2); end
        8: begin step(B_A, 0, 0); want(K_ERR, 1); want(K_STR, 3); want(K_STATE, 4); end
        9: begin step('0, 0, 0); want(K_STATE, 6); want(K_ERR, 0); want(K_PLAY, 0); end
        default: begin step('0, 1, 0); want(K_SEC, 480); want(K_STATE, 6); end
      endcase
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = observe(e.kind);
        n_cmp++;
        if (o !== e.val) begin
          n_bad++;
          $display("FAIL strikes ph%0d %s: got %0h want %0h", ph, kind_name(e.kind), o, e.val);
        end
      end
      $display("strikes ph%0d: state=%0d strikes=%0d error=%0b", ph, state, strikes, error);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [511:0] o;
    load_vis = one_hidden;
    for (int ph = 0; ph < 14; ph++) begin
      case (ph)
        0, 8: begin step(B_ST, 0, 0); want(K_STATE, 1); want(K_DIFF, 1); end
        1, 9: begin step(B_A, 0, 0); want(K_STATE, 2); end
        2, 10: begin step('0, 0, 1); want(K_STATE, 3); want(K_SEC, 480); end
        3: begin repeat (479) step('0, 1, 0); want(K_SEC, 1); want(K_STATE, 3); end
        4: begin step(B_A, 0, 0); want(K_STATE, 4); end
        5: begin repeat (4) step(B_UP, 0, 0); want(K_SEL, 5); end
        6: begin step(B_A, 1, 0); want(K_STATE, 3); want(K_VIS, all_vis); want(K_SEC, 0); end
        7, 12: begin step('0, 0, 0); want(K_STATE, 6); end
        11: begin repeat (480) step('0, 1, 0); want(K_SEC, 0); want(K_STATE, 3); end
        default: begin step(B_ST, 0, 0); want(K_STATE, 1); want(K_DIFF, 1); end
      endcase
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = observe(e.kind);
        n_cmp++;
        if (o !== e.val) begin
          n_bad++;
          $display("FAIL timeout ph%0d %s: got %0h want %0h", ph, kind_name(e.kind), o, e.val);
        end
      end
      $display("timeout ph%0d: state=%0d seconds=%0d", ph, state, seconds_left);
    end
  endtask

  task automatic test_pause();
    exp_t e;
    logic [511:0] o;
`ifdef GAME_PAUSE_EN
    localparam int NPH = 9;
`else
    localparam int NPH = 6;
`endif
    load_vis = one_hidden;
    for (int ph = 0; ph < NPH; ph++) begin
      case (ph)
        0: begin step(B_A, 0, 0); want(K_STATE, 2); end
        1: begin step('0, 0, 1); want(K_STATE, 3); want(K_SEC, 480); end
`ifdef GAME_PAUSE_EN
        2: begin step(B_ST, 0, 0); want(K_STATE, 7); want(K_PLAY, 0); end
        3: begin repeat (10) step(B_UP | B_A, 1, 0); want(K_STATE, 7); want(K_SEC, 480); want(K_PI, 0); end
        4: begin step(B_ST, 0, 0); want(K_STATE, 3); want(K_PLAY, 1); end
        5: begin step('0, 1, 0); want(K_SEC, 479); end
        6: begin step(B_A, 0, 0); want(K_STATE, 4); end
        7: begin step(B_ST, 0, 0); want(K_STATE, 7); end
        default: begin step(B_ST, 0, 0); want(K_STATE, 4); end
`else
        2: begin step(B_ST, 0, 0); want(K_STATE, 3); want(K_PLAY, 1); end
        3: begin step('0, 1, 0); want(K_SEC, 479); end
        4: begin step(B_A, 0, 0); want(K_STATE, 4); end
        default: begin step(B_ST, 0, 0); want(K_STATE, 4); want(K_PLAY, 1); end
`endif
      endcase
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = observe(e.kind);
        n_cmp++;
        if (o !== e.val) begin
          n_bad++;
          $display("FAIL pause ph%0d %s: got %0h want %0h", ph, kind_name(e.kind), o, e.val);
        end
      end
      $display("pause ph%0d: state=%0d seconds=%0d", ph, state, seconds_left);
    end
  endtask

  initial begin
    for (int k = 0; k < CELLS; k++)
      map_ref[k*CW +: CW] = CW'((k * 7) % 9 + 1);
    map_ref[0 +: CW] = CW'(5);
    all_vis = '1;
    one_hidden = '1;
    one_hidden[0] = 1'b0;
    load_map = map_ref;
    load_vis = one_hidden;

    test_reset();
    test_reset_mid_load();
    test_load();
    test_cursor();
    test_pick();
    test_strikes();
    test_timeout();
    test_pause();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/game_fsm_grid.md
Name: game_fsm_grid

Overview:
- Parametrised successor to the fixed 9x9 game controller; supports any BOX x BOX sub-box grid (N = BOX*BOX cells per side).
- Adds NUM_DIFF difficulty levels, a per-difficulty countdown timer, a configurable strike limit, and a valid/ready puzzle-load handshake.
- Owns all game state: FSM, cursor, number picker, board and visibility registers.
- Sits between the debounced button front-end and the map ROM / VGA renderer.

Parameters:
- BOX, 3, sub-box side; N = BOX*BOX; CW = $clog2(N+1) bits per cell; PW = $clog2(N) bits per coordinate.
- NUM_DIFF, 2, number of difficulty levels; DW = max(1, $clog2(NUM_DIFF)).
- MAX_STRIKES, 3, wrong entries that cause defeat; SW = $clog2(MAX_STRIKES+1).
- TIME_BASE, 600, seconds allowed at difficulty 0; TW = $clog2(TIME_BASE+1).
- TIME_STEP, 120, seconds removed per difficulty step; require TIME_BASE > (NUM_DIFF-1)*TIME_STEP.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- tick  in  1  one-cycle 1 Hz enable
- up_button, down_button, left_button, right_button, start_button, a_button, b_button  in  1 each  single-cycle pulses
- load_valid  in  1  map source has a puzzle
- load_map  in  N*N*CW  solution values, row-major, cell (i,j) at bits [(i*N+j)*CW +: CW]
- load_vis  in  N*N  initial visibility, bit i*N+j
- load_ready  out  1  block accepts a puzzle
- state  out  3  current FSM state
- pos_i, pos_j  out  PW each  cursor
- selected_number  out  CW  picker value
- strikes  out  SW  wrong entries so far
- seconds_left  out  TW  countdown
- difficulty  out  DW  chosen level
- board  out  N*N*CW  solution
- visibilities  out  N*N  revealed cells
- error  out  1  one-cycle pulse on a wrong entry
- playing  out  1  high in NAVIGATE or PICK

Behaviour:
- Reset applies when reset==0 at a clk edge. All outputs go to 0 except state=IDLE and selected_number=1.
- States: IDLE=0, SELECT_DIFF=1, LOADING=2, NAVIGATE=3, PICK=4, VICTORY=5, DEFEAT=6, PAUSED=7 (PAUSED reachable only with the feature enabled).
- IDLE: start_button -> SELECT_DIFF.
- SELECT_DIFF:
  - up_button increments difficulty, saturating at NUM_DIFF-1; down_button decrements, saturating at 0.
  - a_button -> LOADING.
- LOADING:
  - load_ready = 1 combinationally in this state only.
  - On load_valid & load_ready, the same edge captures board and visibilities, sets seconds_left = TIME_BASE - difficulty*TIME_STEP, strikes=0, pos=(0,0), selected_number=1, and moves to NAVIGATE.
  - Wait indefinitely while load_valid=0.
- NAVIGATE:
  - Arrow buttons move the cursor modulo N (up from row 0 goes to row N-1, right from column N-1 goes to column 0).
  - At most one move per cycle; priority up > down > left > right.
  - a_button on a hidden cell -> PICK with selected_number=1. a_button on a visible cell is ignored.
- PICK:
  - up_button steps selected_number 1..N and wraps N->1; down_button wraps 1->N.
  - a_button with selected_number == board[cell]: set the visibility bit and -> NAVIGATE.
  - a_button with a mismatch: error=1 for one cycle, strikes+1 (saturating), stay in PICK.
  - b_button -> NAVIGATE with no change. Priority a > b.
- Timer: while playing and tick=1, seconds_left decrements and holds at 0.
- End checks, made on registered values in NAVIGATE/PICK, override all button transitions:
  - strikes==MAX_STRIKES or seconds_left==0 -> DEFEAT.
  - Otherwise, visibilities all ones -> VICTORY.
  - Defeat beats victory when both hold.
- VICTORY/DEFEAT: board, visibilities and difficulty hold; start_button -> SELECT_DIFF.
- Cell index = pos_i*N + pos_j, computed at full width; there is no out-of-range case.
- Reset asserted in any state, including mid-load, returns to reset values on that edge; a concurrent load_valid is dropped.

Optional Feature:
- Macro GAME_PAUSE_EN.
- Defined:
  - start_button in NAVIGATE/PICK -> PAUSED, remembering the prior state.
  - PAUSED freezes the timer and ignores all other buttons.
  - start_button in PAUSED returns to the remembered state.
  - playing=0 while paused.
- Undefined: start_button is ignored during play, and state 7 is unreachable (decodes as IDLE).

Decomposition:
- Package game_pkg holds:
  - state encodings;
  - derived-width helper functions (cell/coordinate widths);
  - the time-limit function of difficulty.
- One sub-module, cursor_ctrl: wrap-around pos_i/pos_j update with button priority, enabled only in NAVIGATE.

Test Plan:
- BOX=3: reset=0 for 2 cycles then start, a, then load_valid with 80 visible cells (cell (0,0) hidden, solution 5). Expect state=NAVIGATE one cycle after the handshake, seconds_left=600, load_ready=0.
- From (0,0): up_button -> pos_i=8; left_button -> pos_j=8; up+right in the same cycle -> pos_i=7 with pos_j unchanged.
- PICK on (0,0): down_button -> selected_number=9; a -> error pulses one cycle and strikes=1. Then 5 up-presses (9 wraps to 1, then 2,3,4,5) and a -> cell visible, VICTORY next cycle.
- Difficulty 1, timer 480: force strikes to 2, then a wrong entry in the same cycle the last hidden cell would be solved. Expect DEFEAT, error=1.
- 480 ticks with no input -> seconds_left=0 -> DEFEAT; start -> SELECT_DIFF with difficulty still 1.
- GAME_PAUSE_EN defined: start in NAVIGATE -> PAUSED; 10 ticks leave seconds_left unchanged; start -> NAVIGATE.
